// File: rtl/acc_series_sequencer.sv
// acc_series_sequencer
//   Accumulates tap_b terms of the arithmetic series first_val,
//   first_val+step, first_val+2*step, ... after a start request. The running
//   sum after tap_a terms is captured on port_A and the final sum on port_B.
//   The accumulator either wraps mod 2^WIDTH or clamps at 2^WIDTH-1 (SAT_EN).
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-low reset
//   start      : run request, honoured only while idle
//   first_val  : first term, sampled on accepted start
//   step       : term increment, sampled on accepted start
//   tap_a      : term count for the port_A capture, sampled on start
//   tap_b      : total term count / port_B capture, sampled on start
//   port_A     : partial sum after tap_a terms
//   port_B     : final sum after tap_b terms
//   a_valid    : port_A loaded during the current/last run
//   busy       : high while accumulating
//   done       : one-cycle pulse when port_B is loaded
//   overflow   : sticky per run, some accumulate exceeded 2^WIDTH-1
module acc_series_sequencer #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] first_val,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] tap_a,
  input  logic [CNT_W-1:0] tap_b,
  output logic [WIDTH-1:0] port_A,
  output logic [WIDTH-1:0] port_B,
  output logic             a_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] step_q,     step_d;
  logic [CNT_W-1:0] tap_a_q,    tap_a_d;
  logic [CNT_W-1:0] tap_b_q,    tap_b_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] k_q,        k_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] port_a_q,   port_a_d;
  logic [WIDTH-1:0] port_b_q,   port_b_d;
  logic             a_valid_q,  a_valid_d;
  logic             done_q,     done_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;

  // Reduce the WIDTH+1 bit sum to WIDTH bits: drop the carry when wrapping,
  // pin to all-ones when saturating. Because terms are never negative, a
  // clamped accumulator stays clamped for the rest of the run.
  function automatic logic [WIDTH-1:0] wrap_or_sat(input logic [WIDTH:0] s);
    if (SAT_EN != 0 && s[WIDTH]) begin
      return '1;
    end
    return s[WIDTH-1:0];
  endfunction

  always_comb begin
    sum      = {1'b0, acc_q} + {{(WIDTH+1-CNT_W){1'b0}}, cnt_q};
    acc_next = wrap_or_sat(sum);
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tap_a_d    = tap_a_q;
    tap_b_d    = tap_b_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    port_a_d   = port_a_q;
    port_b_d   = port_b_q;
    a_valid_d  = a_valid_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        a_valid_d  = 1'b0;
        overflow_d = 1'b0;
        if (tap_b != '0) begin
          step_d  = step;
          tap_a_d = tap_a;
          tap_b_d = tap_b;
          cnt_d   = first_val;
          acc_d   = '0;
          k_d     = '0;
          state_d = ACC;
        end else begin
          // Empty series: report a zero result immediately without running.
          port_b_d = '0;
          done_d   = 1'b1;
        end
      end
    end else begin
      acc_d = acc_next;
      cnt_d = cnt_q + step_q;
      k_d   = k_q + CNT_W'(1);
      if (sum[WIDTH]) begin
        overflow_d = 1'b1;
      end
      // k counts terms already summed, so k==tap-1 is the edge on which the
      // tap-th term lands; captures take the freshly computed value.
      if (tap_a_q != '0 && k_q == tap_a_q - CNT_W'(1)) begin
        port_a_d  = acc_next;
        a_valid_d = 1'b1;
      end
      if (k_q == tap_b_q - CNT_W'(1)) begin
        port_b_d = acc_next;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      tap_a_q    <= '0;
      tap_b_q    <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      port_a_q   <= '0;
      port_b_q   <= '0;
      a_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tap_a_q    <= tap_a_d;
      tap_b_q    <= tap_b_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      port_a_q   <= port_a_d;
      port_b_q   <= port_b_d;
      a_valid_q  <= a_valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign port_A   = port_a_q;
  assign port_B   = port_b_q;
  assign a_valid  = a_valid_q;
  assign busy     = (state_q == ACC);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_acc_series_sequencer.sv
// Bench for acc_series_sequencer: a wrapping instance and a saturating
// instance share one stimulus stream and are compared against a
// term-by-term arithmetic model of the series.
module tb_acc_series_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] first_val = '0, step = '0, tap_a = '0, tap_b = '0;

  logic [7:0] pa_w, pb_w, pa_s, pb_s;
  logic       av_w, busy_w, done_w, ovf_w;
  logic       av_s, busy_s, done_s, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acc_series_sequencer #(.WIDTH(8), .CNT_W(8), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .first_val(first_val),
    .step(step), .tap_a(tap_a), .tap_b(tap_b), .port_A(pa_w), .port_B(pb_w),
    .a_valid(av_w), .busy(busy_w), .done(done_w), .overflow(ovf_w));

  acc_series_sequencer #(.WIDTH(8), .CNT_W(8), .SAT_EN(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .first_val(first_val),
    .step(step), .tap_a(tap_a), .tap_b(tap_b), .port_A(pa_s), .port_B(pb_s),
    .a_valid(av_s), .busy(busy_s), .done(done_s), .overflow(ovf_s));

  // Reference: sum the series term by term with plain integers.
  task automatic model(input int f, input int s, input int ta, input int tb,
                       input bit sat, output int pa, output int pb,
                       output bit ovf, output bit av);
    int acc;
    acc = 0; pa = 0; ovf = 0; av = 0;
    for (int i = 0; i < tb; i++) begin
      int term, sm;
      term = (f + i * s) % 256;
      sm   = acc + term;
      if (sm > 255) begin
        ovf = 1;
        acc = sat ? 255 : sm - 256;
      end else begin
        acc = sm;
      end
      if (i + 1 == ta) begin
        pa = acc;
        av = 1;
      end
    end
    pb = acc;
  endtask

  // Present a configuration and hold start across exactly one rising edge.
  task automatic start_run(input int f, input int s, input int ta, input int tb);
    first_val = 8'(f); step = 8'(s); tap_a = 8'(ta); tap_b = 8'(tb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done. cyc = edges after the accept edge; arise = first
  // cycle a_valid was seen high (-1 if never). At cycle glitch_at a start
  // request with unrelated cfg is pulsed while the run is in progress.
  task automatic wait_done(input int glitch_at, output int cyc, output int arise);
    cyc = 0; arise = -1;
    forever begin
      if (av_w && arise < 0) arise = cyc;
      if (done_w) break;
      if (cyc >= 300) break;
      if (cyc == glitch_at) begin
        first_val = 8'd9; step = 8'd2; tap_a = 8'd1; tap_b = 8'd3;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pa_w, pb_w, av_w, busy_w, done_w, ovf_w} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got A=%0d B=%0d av=%b busy=%b done=%b ovf=%b, want all 0",
               pa_w, pb_w, av_w, busy_w, done_w, ovf_w);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_t1;
    int cyc, arise;
    start_run(0, 1, 11, 21);
    n_checks++;
    if (busy_w !== 1'b1) begin
      n_fail++; $display("FAIL t1_busy: got %b want 1", busy_w);
    end
    wait_done(-1, cyc, arise);
    n_checks++;
    if (cyc !== 21) begin
      n_fail++; $display("FAIL t1_latency: got %0d want 21", cyc);
    end
    n_checks++;
    if (arise !== 11) begin
      n_fail++; $display("FAIL t1_avalid_rise: got %0d want 11", arise);
    end
    n_checks++;
    if (pa_w !== 8'd55 || pb_w !== 8'd210 || ovf_w !== 1'b0 || av_w !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_result: got A=%0d B=%0d ovf=%b av=%b want A=55 B=210 ovf=0 av=1",
               pa_w, pb_w, ovf_w, av_w);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done_w !== 1'b0 || busy_w !== 1'b0) begin
      n_fail++; $display("FAIL t1_done_pulse: got done=%b busy=%b want 0 0", done_w, busy_w);
    end
  endtask

  task automatic test_t2;
    int cyc, arise;
    start_run(0, 1, 0, 23);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (pb_w !== 8'd253 || ovf_w !== 1'b0 || av_w !== 1'b0 || pa_w !== 8'd55) begin
      n_fail++;
      $display("FAIL t2_tb23: got B=%0d ovf=%b av=%b A=%0d want B=253 ovf=0 av=0 A=55",
               pb_w, ovf_w, av_w, pa_w);
    end
    start_run(0, 1, 0, 24);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (pb_w !== 8'd20 || ovf_w !== 1'b1) begin
      n_fail++; $display("FAIL t2_tb24_wrap: got B=%0d ovf=%b want B=20 ovf=1", pb_w, ovf_w);
    end
    n_checks++;
    if (pb_s !== 8'd255 || ovf_s !== 1'b1) begin
      n_fail++; $display("FAIL t2_tb24_sat: got B=%0d ovf=%b want B=255 ovf=1", pb_s, ovf_s);
    end
  endtask

  task automatic test_t3;
    int cyc, arise;
    start_run(0, 1, 5, 24);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (pb_s !== 8'd255 || ovf_s !== 1'b1 || pa_s !== 8'd10 || av_s !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_sat: got A=%0d B=%0d ovf=%b av=%b want A=10 B=255 ovf=1 av=1",
               pa_s, pb_s, ovf_s, av_s);
    end
    n_checks++;
    if (pb_w !== 8'd20 || pa_w !== 8'd10) begin
      n_fail++; $display("FAIL t3_wrap: got A=%0d B=%0d want A=10 B=20", pa_w, pb_w);
    end
  endtask

  task automatic test_t4;
    int cyc, arise;
    start_run(3, 4, 30, 4);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (cyc !== 4 || pb_w !== 8'd36 || av_w !== 1'b0 || pa_w !== 8'd10 || ovf_w !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_result: got cyc=%0d B=%0d av=%b A=%0d ovf=%b want 4 36 0 10 0",
               cyc, pb_w, av_w, pa_w, ovf_w);
    end
  endtask

  task automatic test_t5;
    int cyc, arise;
    start_run(0, 1, 11, 21);
    wait_done(6, cyc, arise);
    n_checks++;
    if (cyc !== 21 || pa_w !== 8'd55 || pb_w !== 8'd210 || ovf_w !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_ignore_start: got cyc=%0d A=%0d B=%0d ovf=%b want 21 55 210 0",
               cyc, pa_w, pb_w, ovf_w);
    end
    @(posedge clk); #1;
    start_run(7, 7, 3, 0);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (cyc !== 0 || pb_w !== 8'd0 || pa_w !== 8'd55 || av_w !== 1'b0 || busy_w !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_tapb_zero: got cyc=%0d B=%0d A=%0d av=%b busy=%b want 0 0 55 0 0",
               cyc, pb_w, pa_w, av_w, busy_w);
    end
  endtask

  task automatic test_t6;
    int cyc, arise;
    start_run(0, 1, 11, 21);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({pa_w, pb_w, av_w, busy_w, done_w, ovf_w} !== 20'd0) begin
      n_fail++;
      $display("FAIL t6_midrun_reset: got A=%0d B=%0d av=%b busy=%b done=%b ovf=%b want all 0",
               pa_w, pb_w, av_w, busy_w, done_w, ovf_w);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    start_run(0, 1, 11, 21);
    wait_done(-1, cyc, arise);
    n_checks++;
    if (cyc !== 21 || pa_w !== 8'd55 || pb_w !== 8'd210) begin
      n_fail++;
      $display("FAIL t6_rerun: got cyc=%0d A=%0d B=%0d want 21 55 210", cyc, pa_w, pb_w);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, arise;
    start_run(1, 2, 2, 3);
    wait_done(-1, cyc, arise);
    // Start issued during the done cycle must be taken on the next edge.
    start_run(5, 1, 1, 2);
    n_checks++;
    if (busy_w !== 1'b1 || done_w !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy_w, done_w);
    end
    wait_done(-1, cyc, arise);
    n_checks++;
    if (cyc !== 2 || pa_w !== 8'd5 || pb_w !== 8'd11) begin
      n_fail++; $display("FAIL b2b_result: got cyc=%0d A=%0d B=%0d want 2 5 11", cyc, pa_w, pb_w);
    end
  endtask

  task automatic test_random;
    int cyc, arise, f, s, ta, tb;
    int pa0, pb0, pa1, pb1;
    bit ov0, av0, ov1, av1;
    int exp_pa_w, exp_pa_s;
    exp_pa_w = pa_w; exp_pa_s = pa_s;  // carry-over baseline from prior directed run
    exp_pa_w = 5; exp_pa_s = 5;
    for (int r = 0; r < 25; r++) begin
      f  = int'($urandom_range(0, 255));
      s  = int'($urandom_range(0, 255));
      tb = int'($urandom_range(0, 40));
      ta = int'($urandom_range(0, 45));
      model(f, s, ta, tb, 1'b0, pa0, pb0, ov0, av0);
      model(f, s, ta, tb, 1'b1, pa1, pb1, ov1, av1);
      if (av0) exp_pa_w = pa0;
      if (av1) exp_pa_s = pa1;
      start_run(f, s, ta, tb);
      wait_done(-1, cyc, arise);
      n_checks++;
      if (cyc !== tb || pb_w !== 8'(pb0) || pa_w !== 8'(exp_pa_w) || ovf_w !== ov0 || av_w !== av0) begin
        n_fail++;
        $display("FAIL rand_wrap[%0d]: got cyc=%0d B=%0d A=%0d ovf=%b av=%b want %0d %0d %0d %b %b",
                 r, cyc, pb_w, pa_w, ovf_w, av_w, tb, pb0, exp_pa_w, ov0, av0);
      end
      n_checks++;
      if (pb_s !== 8'(pb1) || pa_s !== 8'(exp_pa_s) || ovf_s !== ov1 || av_s !== av1) begin
        n_fail++;
        $display("FAIL rand_sat[%0d]: got B=%0d A=%0d ovf=%b av=%b want %0d %0d %b %b",
                 r, pb_s, pa_s, ovf_s, av_s, pb1, exp_pa_s, ov1, av1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_t2();
    test_t3();
    test_t4();
    test_t5();
    test_t6();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
